// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encoding for the UART-driven bus initiator.
package uart_bus_master_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_REQ,
      ST_ACC,
      ST_WAIT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/uart_bus_master_shreg.sv
// 32-bit byte-wise shift register: shifts a byte in at the LSB end (MSB-first streams)
// or takes a parallel load; the top byte is the next byte out.
module uart_bus_master_shreg
   import uart_bus_master_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] load_val_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] q_o
);

   logic [31:0] q_q;
   logic [31:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (shift_i) begin
         q_d = {q_q[23:0], byte_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/uart_bus_master.sv
// Decodes UART read/write frames and issues the accesses on the memory bus.
// Optional inter-byte frame timeout: define UART_BUS_MASTER_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for opcode byte
// ST_ADDR  | collecting 4 address bytes
// ST_DATA  | collecting 4 write-data bytes
// ST_REQ   | bus_req high, waiting for bus_gnt
// ST_ACC   | one-cycle mem_wmask / mem_rstrb strobe
// ST_WAIT  | waiting for the access to finish
// ST_RESP  | sending ACK, NAK or 4 read-data bytes
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1200000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rbusy,
   input  logic        mem_wbusy
);

   state_e      state_q;
   logic        is_rd_q;
   logic        rd_resp_q;
   logic [1:0]  cnt_q;
   logic [7:0]  code_q;
   logic        tx_valid_q;
   logic        bus_req_q;
   logic        rstrb_q;
   logic [3:0]  wmask_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] addr_sh;
   logic [31:0] data_sh;
   logic        tx_fire;
   logic        addr_shift;
   logic        data_shift;
   logic        data_load;
   logic        to_expire;

   assign tx_fire    = tx_valid_q & tx_ready;
   assign addr_shift = rx_valid & (state_q == ST_ADDR);
   assign data_shift = (rx_valid & (state_q == ST_DATA)) | (tx_fire & rd_resp_q);
   assign data_load  = (state_q == ST_WAIT) & is_rd_q & ~mem_rbusy;

   uart_bus_master_shreg u_addr_sh (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (1'b0),
      .load_val_i (32'h0),
      .shift_i    (addr_shift),
      .byte_i     (rx_data),
      .q_o        (addr_sh)
   );

   // Holds write data while collecting, then the read word being shifted out.
   uart_bus_master_shreg u_data_sh (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (data_load),
      .load_val_i (mem_rdata),
      .shift_i    (data_shift),
      .byte_i     ((state_q == ST_DATA) ? rx_data : 8'h00),
      .q_o        (data_sh)
   );

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= TO_RELOAD;
      end else if (!(state_q inside {ST_ADDR, ST_DATA}) || rx_valid) begin
         to_cnt_q <= TO_RELOAD;
      end else if (to_cnt_q != '0) begin
         to_cnt_q <= to_cnt_q - 1'b1;
      end
   end

   assign to_expire = (to_cnt_q == '0) & ~rx_valid & (state_q inside {ST_ADDR, ST_DATA});
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign to_expire      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         is_rd_q    <= 1'b0;
         rd_resp_q  <= 1'b0;
         cnt_q      <= 2'd0;
         code_q     <= 8'h00;
         tx_valid_q <= 1'b0;
         bus_req_q  <= 1'b0;
         rstrb_q    <= 1'b0;
         wmask_q    <= 4'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
      end else begin
         rstrb_q <= 1'b0;
         wmask_q <= 4'h0;
         case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  cnt_q <= 2'd0;
                  if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                     is_rd_q <= (rx_data == OP_READ);
                     state_q <= ST_ADDR;
                  end else begin
                     is_rd_q    <= 1'b0;
                     code_q     <= RSP_NAK;
                     tx_valid_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_ADDR: begin
               if (to_expire) begin
                  state_q <= ST_IDLE;
               end else if (rx_valid) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     if (is_rd_q) begin
                        addr_q    <= {addr_sh[23:0], rx_data};
                        bus_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (to_expire) begin
                  state_q <= ST_IDLE;
               end else if (rx_valid) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     addr_q    <= addr_sh;
                     wdata_q   <= {data_sh[23:0], rx_data};
                     bus_req_q <= 1'b1;
                     state_q   <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (bus_gnt) begin
                  if (is_rd_q) begin
                     rstrb_q <= 1'b1;
                  end else begin
                     wmask_q <= 4'hF;
                  end
                  state_q <= ST_ACC;
               end
            end
            ST_ACC: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // Grant is no longer looked at: the access has already been issued.
               if (is_rd_q ? ~mem_rbusy : ~mem_wbusy) begin
                  bus_req_q  <= 1'b0;
                  tx_valid_q <= 1'b1;
                  cnt_q      <= 2'd0;
                  state_q    <= ST_RESP;
                  if (is_rd_q) begin
                     rd_resp_q <= 1'b1;
                  end else begin
                     code_q <= RSP_ACK;
                  end
               end
            end
            ST_RESP: begin
               if (tx_fire) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (!rd_resp_q || cnt_q == 2'd3) begin
                     tx_valid_q <= 1'b0;
                     rd_resp_q  <= 1'b0;
                     state_q    <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_data   = rd_resp_q ? data_sh[31:24] : code_q;
   assign tx_valid  = tx_valid_q;
   assign bus_req   = bus_req_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign mem_rstrb = rstrb_q;

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Byte-stream-driven bus initiator: decodes read/write command frames arriving from a UART receive byte stream and issues the matching accesses on the FemtoRV32-style memory bus (mem_addr/mem_wdata/mem_wmask/mem_rstrb/mem_rdata/busy). It is the initiator-side counterpart of the memory-mapped peripherals, giving a host PC debug and boot-load access to RAM and peripherals. It sits between the UART byte interface and the SoC bus arbiter, requesting the bus from the CPU via bus_req/bus_gnt.

## Interface
- TIMEOUT_CYCLES, 1200000, inter-byte timeout in clk cycles (only with timeout feature)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready
- bus_req  out  1  bus ownership request to arbiter
- bus_gnt  in  1  arbiter grant; initiator drives strobes only while high
- mem_addr  out  32  access address
- mem_wdata  out  32  write data
- mem_wmask  out  4  byte write mask (one-cycle pulse)
- mem_rstrb  out  1  read strobe (one-cycle pulse)
- mem_rdata  in  32  read data
- mem_rbusy  in  1  read in progress
- mem_wbusy  in  1  write in progress

## Operation
- Frame formats, multi-byte fields MSB first: write = 0x57, A3..A0, D3..D0; read = 0x52, A3..A0.
- States: IDLE -> ADDR (4 bytes) -> DATA (4 bytes, write only) -> REQ -> ACC -> WAIT -> RESP -> IDLE.
- IDLE: on rx_valid, 0x57/0x52 latches opcode and goes to ADDR; any other byte loads NAK 0x15 and goes to RESP.
- REQ: bus_req=1; waits for bus_gnt.
- ACC (one cycle, gnt high): write drives mem_wmask=4'hF; read drives mem_rstrb=1.
- WAIT: write leaves when mem_wbusy=0; read captures mem_rdata on first cycle mem_rbusy=0.
- RESP: write sends ACK 0x06 (1 byte); read sends 4 data bytes MSB first; each byte advances on tx_valid&tx_ready. bus_req drops on entry to RESP.
- rx_valid during REQ/ACC/WAIT/RESP is ignored (dropped).
- mem_addr/mem_wdata hold the last latched value when idle; address is not aligned/modified (low 2 bits passed through).
- Byte counter wraps 3 -> 0 between ADDR and DATA.

## Timing
- Reset: all outputs 0 (tx_data 0x00, tx_valid 0, bus_req 0, mem_* 0), state IDLE.
- Last frame byte -> bus_req high next cycle.
- Grant already high: mem strobe 1 cycle after bus_req rises; strobe never longer than one cycle.
- Zero-busy bus: read data registered 1 cycle after mem_rstrb; first tx_valid the following cycle.
- bus_gnt deassert during WAIT is ignored (access already issued).
- rst mid-frame or mid-access: immediate return to IDLE, partial frame discarded, strobes and tx_valid cleared.

## Configuration
- UART_BUS_MASTER_TIMEOUT_EN defined: counter reloads on each accepted byte in ADDR/DATA; reaching TIMEOUT_CYCLES without a byte aborts the frame silently to IDLE. Not applied in REQ/WAIT/RESP.
- Undefined: no counter; partial frame waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Shared package uart_bus_master_pkg: opcode constants (0x57, 0x52), response codes (ACK 0x06, NAK 0x15), state enum.
- One sub-module natural: uart_bus_master_shreg, 32-bit byte-wise shift register (shift-in MSB-first for addr/data, shift-out MSB-first for read response), instantiated for address and data.

## Test plan
- Write frame 57 00 00 00 10 DE AD BE EF, gnt tied 1 -> one-cycle mem_wmask=F at addr 0x00000010, wdata 0xDEADBEEF; tx byte 0x06.
- Read frame 52 00 40 00 04, mem_rdata=0x12345678, rbusy 2 cycles -> mem_rstrb one pulse, tx bytes 12 34 56 78 in order.
- Bad opcode 0xA5 -> tx 0x15, no bus_req, no strobes; next valid frame executes normally.
- bus_gnt held low 50 cycles after write frame -> bus_req high throughout, no mem_wmask until gnt, then single pulse.
- tx_ready low 20 cycles during read response, plus rst asserted mid-address bytes on second frame -> bytes held stable, then all outputs 0 and next frame decoded from scratch.
- With UART_BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 52 00 then stall 101 cycles -> frame dropped; fresh 52 00 00 00 00 read completes.
